// File: rtl/sram_bus_master_if.sv
// sram_bus_master_if: groups the command/response handshake and SRAM control pins.
// Ports summary:
//   cmd_valid/cmd_ready/cmd_we/cmd_addr/cmd_wdata : command channel into the master
//   rsp_valid/rsp_data                            : read response out of the master
//   sram_addr/ncs/noe/nwe                         : SRAM address and active-low strobes
// The shared data bus stays a plain inout port on the master.
interface sram_bus_master_if #(
  parameter int B  = 7,
  parameter int AW = 12
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [B:0]    cmd_wdata;
  logic          rsp_valid;
  logic [B:0]    rsp_data;
  logic [AW-1:0] sram_addr;
  logic          ncs;
  logic          noe;
  logic          nwe;
  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_data, sram_addr, ncs, noe, nwe
  );
  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_data, sram_addr, ncs, noe, nwe
  );
endinterface

// File: rtl/sram_bus_master.sv
// sram_bus_master: single-command asynchronous SRAM bus master (SETUP/STROBE/HOLD/TURN cycle).
// Ports summary:
//   clk       : clock, all state changes on rising edge
//   reset     : asynchronous active-low reset
//   bus       : sram_bus_master_if.master (command, response, address and strobes)
//   sram_data : shared bidirectional data bus, driven only during a write
module sram_bus_master #(
  parameter int B    = 7,
  parameter int AW   = 12,
  parameter int WAIT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_bus_master_if.master    bus,
  inout  wire  [B:0]           sram_data
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;
  state_t     state;
  logic [3:0] cnt;
  logic       we;
  logic       drive;
  logic [B:0] wdata;
  // drive is registered and only set for writes, so the slave (which drives on noe=0) never contends
  assign sram_data = drive ? wdata : 'z;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      we            <= 1'b0;
      drive         <= 1'b0;
      wdata         <= '0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.sram_addr <= '0;
      bus.ncs       <= 1'b1;
      bus.noe       <= 1'b1;
      bus.nwe       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            state         <= SETUP;
            we            <= bus.cmd_we;
            wdata         <= bus.cmd_wdata;
            drive         <= bus.cmd_we;
            bus.sram_addr <= bus.cmd_addr;
            bus.ncs       <= 1'b0;
            bus.cmd_ready <= 1'b0;
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end
        SETUP: begin
          state   <= STROBE;
          cnt     <= 4'(WAIT);
          bus.noe <= we;
          bus.nwe <= !we;
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            state         <= HOLD;
            bus.noe       <= 1'b1;
            bus.nwe       <= 1'b1;
            bus.rsp_valid <= !we;
            if (!we) bus.rsp_data <= sram_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          state         <= TURN;
          bus.ncs       <= 1'b1;
          bus.rsp_valid <= 1'b0;
          drive         <= 1'b0;
        end
        TURN: begin
          state         <= IDLE;
          bus.cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_bus_master.sv
// tb_sram_bus_master: directed scoreboard bench for sram_bus_master (WAIT=2 and WAIT=0 builds).
module tb_sram_bus_master;
  localparam int B  = 7;
  localparam int AW = 12;
  localparam int W  = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [B:0] exp_q[$];
  logic [B:0] exp_q0[$];
  logic [B:0] slave_q = 8'hA5;
  logic [B:0] slave_q0 = 8'h5A;
  logic [B:0] last_rd = '0;
  always #5 clk = ~clk;
  sram_bus_master_if #(.B(B), .AW(AW)) bus ();
  sram_bus_master_if #(.B(B), .AW(AW)) bus0 ();
  wire [B:0] sram_data;
  wire [B:0] sram_data0;
  // slave drives on ncs=0 && noe=0; bench pulls the bus to 0 while deselected to expose a stray master drive
  assign sram_data  = (!bus.ncs && !bus.noe) ? slave_q : (bus.ncs ? '0 : 'z);
  assign sram_data0 = (!bus0.ncs && !bus0.noe) ? slave_q0 : (bus0.ncs ? '0 : 'z);
  sram_bus_master #(.B(B), .AW(AW), .WAIT(W)) dut (
    .clk(clk), .reset(reset), .bus(bus.master), .sram_data(sram_data));
  sram_bus_master #(.B(B), .AW(AW), .WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.master), .sram_data(sram_data0));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 32'(exp_q.size()), 1);
      else chk("rsp_data_sb", bus.rsp_data, exp_q.pop_front());
    end
    if (bus0.rsp_valid) begin
      if (exp_q0.size() == 0) chk("rsp0_unexpected", 32'(exp_q0.size()), 1);
      else chk("rsp0_data_sb", bus0.rsp_data, exp_q0.pop_front());
    end
  end
  // call at a negedge where cmd_ready=1; returns at the negedge of cycle W+5 (ready again)
  task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [B:0] wd,
                     input logic [B:0] rd, input logic hold);
    chk("ready_before", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    slave_q       = rd;
    if (!we) exp_q.push_back(rd);
    @(posedge clk);
    for (int k = 1; k <= W + 5; k++) begin
      @(negedge clk);
      if (!hold) bus.cmd_valid = 1'b0;
      else if (k < W + 5) begin
        bus.cmd_we   = !we;
        bus.cmd_addr = ~addr;
      end
      if (!we && k == W + 3) last_rd = rd;
      chk($sformatf("ncs_c%0d", k), bus.ncs, (k <= W + 3) ? 0 : 1);
      chk($sformatf("noe_c%0d", k), bus.noe, (!we && k >= 2 && k <= W + 2) ? 0 : 1);
      chk($sformatf("nwe_c%0d", k), bus.nwe, (we && k >= 2 && k <= W + 2) ? 0 : 1);
      chk($sformatf("ready_c%0d", k), bus.cmd_ready, (k == W + 5) ? 1 : 0);
      chk($sformatf("rsp_valid_c%0d", k), bus.rsp_valid, (!we && k == W + 3) ? 1 : 0);
      chk($sformatf("rsp_data_c%0d", k), bus.rsp_data, last_rd);
      chk($sformatf("addr_c%0d", k), bus.sram_addr, addr);
      if (we && k <= W + 3) chk($sformatf("wdata_c%0d", k), sram_data, wd);
      if (!we && k >= 2 && k <= W + 2) chk($sformatf("rdata_bus_c%0d", k), sram_data, rd);
      if (k >= W + 4) chk($sformatf("bus_released_c%0d", k), sram_data, 0);
    end
  endtask
  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus0.cmd_valid = 1'b0; bus0.cmd_we = 1'b0; bus0.cmd_addr = '0; bus0.cmd_wdata = '0;
    @(negedge clk);
    chk("rst_ncs", bus.ncs, 1);
    chk("rst_noe", bus.noe, 1);
    chk("rst_nwe", bus.nwe, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_addr", bus.sram_addr, 0);
    chk("rst_bus", sram_data, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", bus.cmd_ready, 1);
    chk("ready0_after_rst", bus0.cmd_ready, 1);
    txn(1'b0, 12'h012, 8'h00, 8'hA5, 1'b0);
    txn(1'b1, 12'h0FF, 8'h3C, 8'hEE, 1'b0);
    chk("rsp_data_after_write", bus.rsp_data, 8'hA5);
    for (int i = 0; i < 4; i++)
      txn(i[0], AW'(12'h100 + i), B'(8'h10 + i), B'(8'h80 + i), 1'b1);
    bus.cmd_valid = 1'b0;
    // reset during STROBE of a read: transaction is discarded, no response queued
    bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_addr = 12'h321; slave_q = 8'hC3;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_noe_low", bus.noe, 0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ncs", bus.ncs, 1);
    chk("mid_rst_noe", bus.noe, 1);
    chk("mid_rst_nwe", bus.nwe, 1);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_bus", sram_data, 0);
    last_rd = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    txn(1'b0, 12'hABC, 8'h00, 8'h69, 1'b0);
    // WAIT=0 build
    bus0.cmd_valid = 1'b1; bus0.cmd_we = 1'b0; bus0.cmd_addr = 12'h055;
    exp_q0.push_back(8'h5A);
    @(posedge clk);
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    chk("w0_setup_ncs", bus0.ncs, 0);
    chk("w0_setup_noe", bus0.noe, 1);
    @(negedge clk);
    chk("w0_strobe_noe", bus0.noe, 0);
    @(negedge clk);
    chk("w0_hold_noe", bus0.noe, 1);
    chk("w0_rsp_valid", bus0.rsp_valid, 1);
    chk("w0_rsp_data", bus0.rsp_data, 8'h5A);
    @(negedge clk);
    chk("w0_turn_ncs", bus0.ncs, 1);
    chk("w0_turn_rsp_valid", bus0.rsp_valid, 0);
    @(negedge clk);
    chk("w0_ready", bus0.cmd_ready, 1);
    chk("sb_empty", 32'(exp_q.size()), 0);
    chk("sb0_empty", 32'(exp_q0.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
